// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs of the hazard controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic idUsesRt;
  logic idReadsHiLo;
  logic mdStart;
  logic exMemRead;
  logic [4:0] exRt;
  logic branchTaken;
  logic pcWrite;
  logic ifIdWrite;
  logic ifIdFlush;
  logic idExFlush;
  logic mdBusy;
  logic [CNT_W-1:0] stallCycles;
  modport master (
    output idRs, idRt, idUsesRt, idReadsHiLo, mdStart, exMemRead, exRt, branchTaken,
    input pcWrite, ifIdWrite, ifIdFlush, idExFlush, mdBusy, stallCycles
  );
  modport slave (
    input idRs, idRt, idUsesRt, idReadsHiLo, mdStart, exMemRead, exRt, branchTaken,
    output pcWrite, ifIdWrite, ifIdFlush, idExFlush, mdBusy, stallCycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, branch-flush and MDU structural hazard control for a 5-stage MIPS pipeline
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, MD_BUSY} state_t;
  localparam logic [7:0] LAT_M1 = 8'(MD_LATENCY - 1);
  state_t r_state, w_state_nxt;
  logic [7:0] r_md_count, w_md_count_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic w_load_use, w_md_haz, w_stall, w_md_accept;
  assign w_load_use = bus.exMemRead && bus.exRt != 5'd0 &&
                      (bus.exRt == bus.idRs || (bus.idUsesRt && bus.exRt == bus.idRt));
  assign w_md_haz = r_state == MD_BUSY && (bus.idReadsHiLo || bus.mdStart);
  assign w_stall = w_load_use || w_md_haz;
  // a flushed or stalled ID instruction never starts the MDU
  assign w_md_accept = bus.mdStart && !bus.branchTaken && !w_stall;
  // FSM state and MDU occupancy counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_md_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_md_count <= w_md_count_nxt;
    end
  end
  // next state: busy exactly MD_LATENCY cycles; branches never cancel an older mult/div
  always_comb begin
    w_state_nxt = r_state;
    w_md_count_nxt = r_md_count;
    if (r_state == RUN) begin
      w_state_nxt = w_md_accept ? MD_BUSY : RUN;
      w_md_count_nxt = w_md_accept ? LAT_M1 : r_md_count;
    end else begin
      w_state_nxt = r_md_count == 8'd0 ? RUN : MD_BUSY;
      w_md_count_nxt = r_md_count == 8'd0 ? r_md_count : r_md_count - 8'd1;
    end
  end
  // saturating stall counter; flushed cycles are not stalls
  always_ff @(posedge clock) begin
    if (reset)
      r_stall_cycles <= '0;
    else if (!bus.branchTaken && w_stall && !(&r_stall_cycles))
      r_stall_cycles <= r_stall_cycles + 1'b1;
  end
  assign bus.pcWrite = !reset && (bus.branchTaken || !w_stall);
  assign bus.ifIdWrite = !reset && (bus.branchTaken || !w_stall);
  assign bus.ifIdFlush = reset || bus.branchTaken;
  assign bus.idExFlush = reset || bus.branchTaken || w_stall;
  assign bus.mdBusy = !reset && r_state == MD_BUSY;
  assign bus.stallCycles = r_stall_cycles;
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives write-enable and flush of the IF/ID pipeline register and the PC, and the bubble insert into ID/EX.
- Resolves load-use data hazards, taken-branch/jump control hazards, and structural hazards on the multi-cycle multiply/divide unit (MDU).
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
MD_LATENCY, 32, cycles the MDU is occupied after an accepted mult/div; legal range 1..255.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
idRs  input  5  rs field of instruction in ID
idRt  input  5  rt field of instruction in ID
idUsesRt  input  1  ID instruction reads rt as a source
idReadsHiLo  input  1  ID instruction is mfhi/mflo
mdStart  input  1  ID instruction is mult/multu/div/divu
exMemRead  input  1  instruction in EX is a load
exRt  input  5  destination register of the load in EX
branchTaken  input  1  branch/jump resolved taken in EX this cycle
pcWrite  output  1  PC update enable
ifIdWrite  output  1  IF/ID register load enable
ifIdFlush  output  1  IF/ID register clear to nop
idExFlush  output  1  insert bubble (nop) into ID/EX
mdBusy  output  1  MDU occupied
stallCycles  output  CNT_W  saturating count of stall cycles

Behaviour:
Reset:
- While reset=1: pcWrite=0, ifIdWrite=0, ifIdFlush=1, idExFlush=1, mdBusy=0.
- At the clock edge with reset=1: state<=RUN, mdCount<=0, stallCycles<=0.
- Reset mid-MDU operation aborts it. mdBusy=0 in the first cycle after reset deasserts.

Output timing:
- pcWrite, ifIdWrite, ifIdFlush and idExFlush are combinational from the current inputs and state; they act in the same cycle.
- mdBusy and stallCycles are registered.

FSM states: RUN, MD_BUSY. mdBusy=1 exactly in MD_BUSY.

Hazard terms:
- loadUse = exMemRead & (exRt!=0) & ((exRt==idRs) | (idUsesRt & exRt==idRt)).
- mdHaz = (state==MD_BUSY) & (idReadsHiLo | mdStart).
- stall = loadUse | mdHaz.

Priority, evaluated each cycle:
1. branchTaken=1 (flush):
   - ifIdFlush=1, idExFlush=1, pcWrite=1, ifIdWrite=1.
   - Any stall is overridden; the ID instruction is discarded.
   - mdStart from ID is ignored; the MDU is not started.
2. Otherwise stall=1:
   - pcWrite=0, ifIdWrite=0, idExFlush=1, ifIdFlush=0.
   - mdStart is not accepted.
3. Otherwise normal:
   - pcWrite=1, ifIdWrite=1, both flushes 0.

FSM transitions:
- RUN -> MD_BUSY when mdStart=1 and case 3 applies; mdCount<=MD_LATENCY-1.
- MD_BUSY: mdCount decrements each cycle. When mdCount==0, next state is RUN.
- An MDU accepted at edge T is busy in cycles T+1..T+MD_LATENCY.
- branchTaken during MD_BUSY does not cancel the MDU, because the mult/div is older than the branch.
- mdStart while MD_BUSY stalls as a structural hazard. It is accepted in the first RUN cycle, with no idle gap required.

stallCycles:
- +1 on each clock edge where reset=0, branchTaken=0 and stall=1.
- Saturates at all ones and never wraps.

Boundary conditions:
- Load to $0 never stalls.
- Load-use and mdHaz together count as one stall cycle.
- Branch with a simultaneous load-use gives a flush only, and no count.

Test Plan:
1. Reset sequence: assert reset for 2 cycles -> pcWrite=0, ifIdFlush=1, idExFlush=1; after release stallCycles=0, mdBusy=0, pcWrite=1.
2. Load-use: exMemRead=1, exRt=8, idRs=8 for 1 cycle -> pcWrite=0, ifIdWrite=0, idExFlush=1; stallCycles 0->1. Same stimulus with exRt=0, and with idUsesRt=0/idRt=8/idRs=3 -> no stall.
3. Branch overrides stall: branchTaken=1 plus load-use match -> ifIdFlush=1, idExFlush=1, pcWrite=1; stallCycles unchanged.
4. MDU with MD_LATENCY=4:
   - mdStart accepted at edge T; mdBusy=1 for T+1..T+4.
   - mfhi held in ID from T+1 -> stalled exactly 4 cycles, released at T+5; stallCycles=4.
   - Back-to-back mdStart at T+1 -> accepted at edge T+5.
5. Reset mid-MDU: reset at T+2 of a busy period -> mdBusy=0 after reset; mfhi proceeds with no stall.
6. Saturation with CNT_W=3: hold load-use for 10 cycles -> stallCycles reaches 7 and stays at 7.
